// File: rtl/io_mem_responder.sv
// io_mem_responder: zero-wait-state data RAM plus memory-mapped output FIFO,
// STATUS register and optional free-running TIMER for a single-cycle CPU.
// Optional feature macro: IO_TIMER_EN (adds the 32-bit TIMER at 0x108).
//
// Address map (addr[1:0] ignored, all accesses are full words):
//   addr < 4*RAM_WORDS : data RAM
//   0x100              : FIFO data (write pushes, read peeks head)
//   0x104              : STATUS {overflow, empty, full, count[3:0]}
//   0x108              : TIMER (reads 0 when IO_TIMER_EN is undefined)
module io_mem_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    input  logic        memWrite,
    output logic [31:0] readData,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    // Word addresses of the IO registers
    localparam logic [29:0] WORD_FIFO   = 30'h0000_0040;
    localparam logic [29:0] WORD_STATUS = 30'h0000_0041;
    localparam logic [29:0] WORD_TIMER  = 30'h0000_0042;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [31:0]      r_ram  [RAM_WORDS];
    logic [31:0]      r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    // ------------------------------------------------------------------
    // Decode and handshake
    // ------------------------------------------------------------------
    logic [29:0]       w_word;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_is_ram;
    logic              w_is_fifo;
    logic              w_is_status;
    logic              w_is_timer;
    logic              w_full;
    logic              w_empty;
    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_ovf_clr;
    logic [31:0]       w_count_ext;
    logic [31:0]       w_status;
    logic [31:0]       w_head;
    logic [31:0]       w_timer_rd;
    logic              w_unused;

    assign w_word      = addr[31:2];
    assign w_ram_idx   = addr[RAM_AW+1:2];
    assign w_is_ram    = (addr < 32'(4 * RAM_WORDS));
    assign w_is_fifo   = !w_is_ram && (w_word == WORD_FIFO);
    assign w_is_status = !w_is_ram && (w_word == WORD_STATUS);
    assign w_is_timer  = !w_is_ram && (w_word == WORD_TIMER);
    assign w_unused    = ^addr[1:0];

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == {CNT_W{1'b0}});
    assign w_pop       = !w_empty && out_ready;
    assign w_push_req  = memWrite && w_is_fifo;
    // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf_set   = w_push_req && w_full && !w_pop;
    assign w_ovf_clr   = memWrite && w_is_status && writeData[31];

    assign w_count_ext = 32'(r_count);
    assign w_status    = {25'd0, r_overflow, w_empty, w_full, w_count_ext[3:0]};
    assign w_head      = r_fifo[r_rd_ptr];

    assign out_valid   = !w_empty;
    assign out_data    = w_empty ? 32'd0 : w_head;

    // ------------------------------------------------------------------
    // Data RAM (intentionally not reset)
    // ------------------------------------------------------------------

    // RAM write port: store word when the CPU writes inside the RAM window
    always_ff @(posedge clk) begin
        if (memWrite && w_is_ram) begin
            r_ram[w_ram_idx] <= writeData;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------

    // FIFO storage write: entries are data only, pointers make them valid
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_fifo[r_wr_ptr] <= writeData;
        end
    end

    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_overflow_nxt;

    // Next-state for pointers, occupancy count and sticky overflow
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;

        if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end

        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase

        // Software clear wins over a same-cycle overflow event
        if (w_ovf_clr) begin
            w_overflow_nxt = 1'b0;
        end else if (w_ovf_set) begin
            w_overflow_nxt = 1'b1;
        end else begin
            w_overflow_nxt = r_overflow;
        end
    end

    // FIFO control registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // ------------------------------------------------------------------
    // TIMER
    // ------------------------------------------------------------------
`ifdef IO_TIMER_EN
    logic [31:0] r_timer;

    // Free-running counter; a CPU write replaces that cycle's increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= 32'd0;
        end else if (memWrite && w_is_timer) begin
            r_timer <= writeData;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    assign w_timer_rd = r_timer;
`else
    assign w_timer_rd = 32'd0;
`endif

    // ------------------------------------------------------------------
    // CPU read mux (combinational, zero wait states)
    // ------------------------------------------------------------------

    // Select read data for the current address; unmapped addresses read 0
    always_comb begin
        readData = 32'd0;
        if (w_is_ram) begin
            readData = r_ram[w_ram_idx];
        end else if (w_is_fifo) begin
            readData = out_data;
        end else if (w_is_status) begin
            readData = w_status;
        end else if (w_is_timer) begin
            readData = w_timer_rd;
        end else begin
            readData = 32'd0;
        end
    end

endmodule

// File: tb/tb_io_mem_responder.sv
// Directed self-checking bench for io_mem_responder.
// Define IO_TIMER_EN for both bench and design to exercise the TIMER.
module tb_io_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic        memWrite;
    logic [31:0] readData;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_cmp;
    int n_bad;

    io_mem_responder #(
        .RAM_WORDS (64),
        .FIFO_DEPTH(8)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .writeData(writeData),
        .memWrite (memWrite),
        .readData (readData),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single-cycle CPU store; returns at the falling edge after the write edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr      = a;
        writeData = d;
        memWrite  = 1'b1;
        @(negedge clk);
        memWrite  = 1'b0;
    endtask

    // Combinational read check, away from the clock edge
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, readData, exp);
    endtask

    logic [31:0] drain_exp [8];

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        addr      = 32'd0;
        writeData = 32'd0;
        memWrite  = 1'b0;
        out_ready = 1'b0;
        drain_exp = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'hA};

        // Reset state
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        rd_chk("rst_status", 32'h104, 32'h20);
        rd_chk("rst_timer", 32'h108, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // RAM write then same-cycle read, byte offset ignored
        wr(32'h3C, 32'hDEADBEEF);
        rd_chk("ram_3c", 32'h3C, 32'hDEADBEEF);
        rd_chk("ram_3f", 32'h3F, 32'hDEADBEEF);

        // Unmapped address: reads 0, writes ignored
        wr(32'h200, 32'h12345678);
        rd_chk("unmapped", 32'h200, 32'd0);
        rd_chk("fifo_empty_rd", 32'h100, 32'd0);

        // Fill past full: 9th push dropped, overflow set
        for (int i = 1; i <= 9; i++) begin
            wr(32'h100, 32'(i));
        end
        rd_chk("status_full_ovf", 32'h104, 32'h58);
        chk("head_after_fill", out_data, 32'd1);
        rd_chk("peek_head", 32'h100, 32'd1);
        rd_chk("peek_no_pop", 32'h100, 32'd1);

        // Push and pop together while full
        @(negedge clk);
        addr      = 32'h100;
        writeData = 32'hA;
        memWrite  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        memWrite  = 1'b0;
        out_ready = 1'b0;
        rd_chk("status_pushpop_full", 32'h104, 32'h58);

        // Drain and check order
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("drain_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("drain_data_%0d", i), out_data, drain_exp[i]);
            @(negedge clk);
        end
        out_ready = 1'b0;
        rd_chk("status_drained", 32'h104, 32'h60);
        chk("drained_valid", {31'd0, out_valid}, 32'd0);

        // Clear sticky overflow
        wr(32'h104, 32'h8000_0000);
        rd_chk("status_ovf_clr", 32'h104, 32'h20);

        // TIMER load and wrap
        wr(32'h108, 32'hFFFF_FFFE);
`ifdef IO_TIMER_EN
        rd_chk("timer_load", 32'h108, 32'hFFFF_FFFE);
        @(negedge clk);
        rd_chk("timer_inc", 32'h108, 32'hFFFF_FFFF);
        @(negedge clk);
        rd_chk("timer_wrap", 32'h108, 32'd0);
`else
        rd_chk("timer_absent", 32'h108, 32'd0);
        @(negedge clk);
        rd_chk("timer_absent2", 32'h108, 32'd0);
`endif

        // Queue 3 entries then assert reset between edges
        wr(32'h100, 32'h11);
        wr(32'h100, 32'h22);
        wr(32'h100, 32'h33);
        rd_chk("status_three", 32'h104, 32'h03);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
        rd_chk("rst_async_status", 32'h104, 32'h20);

        // Push and pop attempts while reset is held are ignored
        addr      = 32'h100;
        writeData = 32'h99;
        memWrite  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        memWrite  = 1'b0;
        out_ready = 1'b0;
        rd_chk("rst_hold_status", 32'h104, 32'h20);
        rst = 1'b0;

        // First edge after reset accepts a push
        wr(32'h100, 32'h55);
        rd_chk("post_rst_push", 32'h104, 32'h01);
        chk("post_rst_head", out_data, 32'h55);

        // Simultaneous push/pop at a middle count keeps order
        wr(32'h100, 32'h66);
        @(negedge clk);
        addr      = 32'h100;
        writeData = 32'h77;
        memWrite  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        memWrite  = 1'b0;
        out_ready = 1'b0;
        rd_chk("mid_pushpop_status", 32'h104, 32'h02);
        chk("mid_pushpop_head", out_data, 32'h66);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("mid_pop_head", out_data, 32'h77);
        rd_chk("mid_pop_status", 32'h104, 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
